demux_sel_sequencer: RTL
========================

# demux_sel_sequencer

Upstream driver for the 8-way one-hot demux stage. It accepts addressed single-bit requests (destination channel + data bit) over a valid/ready handshake and buffers them in a small FIFO. It replays each request as a registered `d`/`s0`/`s1`/`s2` drive held for a programmable number of cycles. A scan mode steps the select through all eight channels for bring-up and fan-out checks.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `HOLD`, 2: cycles each select/data value is presented; ≥1.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: FIFO can accept; equals !full.
- `in_dest` in 3: destination channel 0..7.
- `in_d` in 1: data bit for that channel.
- `mode` in 1: 0 = addressed (drain FIFO), 1 = scan.
- `d` out 1: data to demux; forced 0 when `out_valid`=0.
- `s0`,`s1`,`s2` out 1 each: select, `{s0,s1,s2}` = channel, `s0` MSB.
- `out_valid` out 1: select/data currently being presented.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO push on `in_valid && in_ready`; stores `{in_dest,in_d}`. Pointers wrap modulo DEPTH; `count` is an exact occupancy, 0..DEPTH.
- Full: `in_ready`=0. A push is refused even if a pop occurs the same cycle; the requester holds `in_valid`/data until accepted.
- Simultaneous push and pop (not full): `count` is unchanged and both occur.
- FSM states:
  - IDLE: `out_valid`=0.
    - If `mode`=0 and FIFO non-empty: pop, load `{s0,s1,s2}`=dest and `d`=data, clear hold counter, go to PRESENT.
    - If `mode`=1: load select 000, `d`=1, go to SCAN.
  - PRESENT: `out_valid`=1; the hold counter increments each cycle. On the last hold cycle (counter = HOLD-1):
    - if `mode`=0 and FIFO non-empty: pop and load the next entry with no gap (stay in PRESENT, counter to 0);
    - otherwise go to IDLE.
  - SCAN: `out_valid`=1, `d`=1. Each HOLD cycles the select increments 000→111 and wraps to 000. At the end of a hold window with `mode`=0, go to IDLE; the FIFO is untouched during scan.
- `mode` is sampled only in IDLE and at hold-window ends; it never truncates a window.
- On return to IDLE: `{s0,s1,s2}` retains its last value and `d` goes to 0.

## Timing
- Reset (async assert, any state): state IDLE, FIFO flushed, `count`=0, `in_ready`=1, `out_valid`=0, `d`=0, `{s0,s1,s2}`=000. Effective immediately on assert, not at the next edge.
- Latency: push accepted at edge T into an empty FIFO in IDLE → outputs driven after edge T+1, held through edge T+1+HOLD.
- Back-to-back entries: windows are contiguous, exactly HOLD cycles each, zero bubbles.
- `in_ready` and `count` reflect the registered state after each edge and are never combinational from `in_valid`.
- All outputs are registered, with no glitches between windows.

## Test plan
- Reset: assert `rst_n`=0 mid-PRESENT with `count`=3 → immediately `out_valid`=0, `d`=0, `{s0,s1,s2}`=000, `count`=0, `in_ready`=1. After release, no stale entry is replayed.
- Single request, HOLD=2: push dest=5, d=1 at edge T → `{s0,s1,s2}`=101, `d`=1, `out_valid`=1 for exactly 2 cycles starting after T+1, then `out_valid`=0, `d`=0, select stays 101.
- Full/backpressure, DEPTH=4: hold `in_valid`=1 with dests 0..5 while `mode`=0.
  - `in_ready` drops when `count`=4.
  - Dest 5 is accepted only after a pop.
  - Order presented is 0,1,2,3,4,5, each for HOLD cycles with no gaps.
- Simultaneous push/pop at `count`=2 → `count` stays 2, and the entries appear in FIFO order.
- Scan mode, HOLD=1, `mode`=1 → select sequence 000,001,…,111,000 on consecutive cycles, `d`=1, `out_valid`=1.
  - Pushes during scan accumulate in `count`.
  - Switching to `mode`=0 drains them after the current window.
- Pointer wrap: push and pop 10 entries with random dests and data → every entry is presented exactly once in order, and `count` returns to 0.

Source files
------------

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: a FIFO of addressed single-bit requests, replayed as
// registered d/s0/s1/s2 drives held for HOLD cycles each, with a scan mode
// that walks the select through all eight channels.
module demux_sel_sequencer #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_dest,
  input  logic                   in_d,
  input  logic                   mode,
  output logic                   d,
  output logic                   s0,
  output logic                   s1,
  output logic                   s2,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_SCAN    = 2'd2;

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_sel;
  logic          r_d;
  logic          r_out_valid;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_last;
  logic [3:0]    w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Full refuses the push even when a pop lands in the same cycle.
  assign w_push  = in_valid && !w_full;
  assign w_last  = (r_hold == HW'(HOLD - 1));
  assign w_head  = r_mem[r_rptr];

  // Pop only from IDLE or at the end of a PRESENT window, and only when draining.
  always_comb begin
    w_pop = 1'b0;
    if (!mode && !w_empty) begin
      if (r_state == S_IDLE)                  w_pop = 1'b1;
      else if (r_state == S_PRESENT && w_last) w_pop = 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_dest, in_d};
  end

  // FIFO pointers and exact occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Presentation FSM; mode is only looked at in IDLE and at window ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_sel       <= '0;
      r_d         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mode) begin
            r_sel       <= 3'd0;
            r_d         <= 1'b1;
            r_out_valid <= 1'b1;
            r_hold      <= '0;
            r_state     <= S_SCAN;
          end else if (!w_empty) begin
            r_sel       <= w_head[3:1];
            r_d         <= w_head[0];
            r_out_valid <= 1'b1;
            r_hold      <= '0;
            r_state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (!w_last) begin
            r_hold <= r_hold + 1'b1;
          end else if (w_pop) begin
            // Next entry back-to-back, no bubble between windows.
            r_sel  <= w_head[3:1];
            r_d    <= w_head[0];
            r_hold <= '0;
          end else begin
            r_d         <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (!w_last) begin
            r_hold <= r_hold + 1'b1;
          end else if (!mode) begin
            r_d         <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_sel  <= r_sel + 1'b1;
            r_hold <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = !w_full;
  assign count     = r_count;
  assign d         = r_d;
  assign out_valid = r_out_valid;
  assign s0        = r_sel[2];
  assign s1        = r_sel[1];
  assign s2        = r_sel[0];

endmodule
